// File: rtl/video_capture_pkg.sv
// Shared definitions for the video capture path: capture FSM states, timing
// counter width and frame-size helper.
package video_capture_pkg;

    localparam int CNT_W  = 12;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 48;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        CAPTURE
    } cap_state_t;

    // Frame size in frame-buffer words (one word per active clock).
    function automatic int frame_words(input int h_rez, input int v_rez);
        return h_rez * v_rez;
    endfunction

    // Timing counters stick at full scale instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/video_timing_meas.sv
// Measures line/frame timing from the registered sync and active-video
// signals and latches the results at every frame start.
module video_timing_meas
    import video_capture_pkg::*;
#(
    parameter logic hsync_active = 1'b0,
    parameter logic vsync_active = 1'b0
) (
    input  logic             clk24,
    input  logic             rst,
    input  logic             hsync_p0,
    input  logic             vsync_p0,
    input  logic             active_p0,
    output logic             frame_start,
    output logic [CNT_W-1:0] fs_h_active,
    output logic [CNT_W-1:0] fs_v_active,
    output logic [CNT_W-1:0] meas_h_active,
    output logic [CNT_W-1:0] meas_v_active,
    output logic [CNT_W-1:0] meas_h_total,
    output logic [CNT_W-1:0] meas_v_total
);

    logic             hsync_p1;
    logic             vsync_p1;
    logic             line_start;
    logic             line_has_act;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] h_act;
    logic [CNT_W-1:0] last_h_act;
    logic [CNT_W-1:0] last_h_tot;
    logic [CNT_W-1:0] v_act;
    logic [CNT_W-1:0] v_tot;

    assign frame_start  = (vsync_p0 == vsync_active) && (vsync_p1 != vsync_active);
    assign line_start   = (hsync_p0 == hsync_active) && (hsync_p1 != hsync_active);
    assign line_has_act = (h_act != '0);

    // Values that latch at this frame start; the line still in progress counts
    // as an active line if it already carried active clocks. Blanking lines do
    // not overwrite the last active line width.
    assign fs_h_active = (line_start && line_has_act) ? h_act : last_h_act;
    assign fs_v_active = line_has_act ? sat_inc(v_act) : v_act;

    always_ff @(posedge clk24) begin
        if (rst) begin
            hsync_p1      <= 1'b0;
            vsync_p1      <= 1'b0;
            h_cnt         <= '0;
            h_act         <= '0;
            last_h_act    <= '0;
            last_h_tot    <= '0;
            v_act         <= '0;
            v_tot         <= '0;
            meas_h_active <= '0;
            meas_v_active <= '0;
            meas_h_total  <= '0;
            meas_v_total  <= '0;
        end else begin
            hsync_p1 <= hsync_p0;
            vsync_p1 <= vsync_p0;

            if (line_start) begin
                h_cnt      <= CNT_W'(1);
                h_act      <= active_p0 ? CNT_W'(1) : '0;
                last_h_tot <= h_cnt;
                if (line_has_act) begin
                    last_h_act <= h_act;
                end
            end else begin
                h_cnt <= sat_inc(h_cnt);
                if (active_p0) begin
                    h_act <= sat_inc(h_act);
                end
            end

            if (frame_start) begin
                v_tot         <= line_start ? CNT_W'(1) : '0;
                v_act         <= '0;
                meas_h_active <= fs_h_active;
                meas_v_active <= fs_v_active;
                meas_h_total  <= line_start ? h_cnt : last_h_tot;
                meas_v_total  <= v_tot;
            end else if (line_start) begin
                v_tot <= sat_inc(v_tot);
                if (line_has_act) begin
                    v_act <= sat_inc(v_act);
                end
            end
        end
    end

endmodule

// File: rtl/video_capture.sv
// Video capture front end: registers the incoming video, locks onto the
// expected resolution and writes each active pixel pair to a frame buffer.
module video_capture
    import video_capture_pkg::*;
#(
    parameter int   hRez         = 320,
    parameter int   vRez         = 480,
    parameter logic hsync_active = 1'b0,
    parameter logic vsync_active = 1'b0
) (
    input  logic              clk24,
    input  logic              rst,
    input  logic [DATA_W-1:0] vid_data,
    input  logic              vid_hsync,
    input  logic              vid_vsync,
    input  logic              vid_active_video,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              locked,
    output logic              frame_done,
    output logic              err,
    output logic [CNT_W-1:0]  meas_h_active,
    output logic [CNT_W-1:0]  meas_v_active,
    output logic [CNT_W-1:0]  meas_h_total,
    output logic [CNT_W-1:0]  meas_v_total
);

    localparam logic [ADDR_W-1:0] FRAME_A = ADDR_W'(frame_words(hRez, vRez));
    localparam logic [CNT_W-1:0]  H_REZ   = CNT_W'(hRez);
    localparam logic [CNT_W-1:0]  V_REZ   = CNT_W'(vRez);

    logic [DATA_W-1:0] data_p0;
    logic              hsync_p0;
    logic              vsync_p0;
    logic              act_p0;

    cap_state_t        state;
    logic [ADDR_W-1:0] addr;
    logic              ovf;
    logic              frame_start;
    logic [CNT_W-1:0]  fs_h_active;
    logic [CNT_W-1:0]  fs_v_active;
    logic              timing_ok;
    logic              cap_next;

    video_timing_meas #(
        .hsync_active (hsync_active),
        .vsync_active (vsync_active)
    ) u_meas (
        .clk24         (clk24),
        .rst           (rst),
        .hsync_p0      (hsync_p0),
        .vsync_p0      (vsync_p0),
        .active_p0     (act_p0),
        .frame_start   (frame_start),
        .fs_h_active   (fs_h_active),
        .fs_v_active   (fs_v_active),
        .meas_h_active (meas_h_active),
        .meas_v_active (meas_v_active),
        .meas_h_total  (meas_h_total),
        .meas_v_total  (meas_v_total)
    );

    assign timing_ok = (fs_h_active == H_REZ) && (fs_v_active == V_REZ);

    // Whether the cycle being processed belongs to a captured frame; at a
    // frame start this already reflects the decision taken for the new frame.
    always_comb begin
        cap_next = (state == CAPTURE);
        if (frame_start) begin
            cap_next = (state != IDLE) && timing_ok;
        end
    end

    // Stage p0 registers the ports; the stage below registers every output.
    always_ff @(posedge clk24) begin
        if (rst) begin
            data_p0    <= '0;
            hsync_p0   <= 1'b0;
            vsync_p0   <= 1'b0;
            act_p0     <= 1'b0;
            state      <= IDLE;
            addr       <= '0;
            ovf        <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_en      <= 1'b0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            data_p0    <= vid_data;
            hsync_p0   <= vid_hsync;
            vsync_p0   <= vid_vsync;
            act_p0     <= vid_active_video;
            wr_data    <= data_p0;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;

            if (frame_start) begin
                addr   <= '0;
                ovf    <= 1'b0;
                locked <= cap_next;
                case (state)
                    IDLE:    state <= MEASURE;
                    MEASURE: if (timing_ok) state <= CAPTURE;
                    CAPTURE: begin
                        if (!timing_ok) begin
                            state <= MEASURE;
                            // An overflow already flagged this frame as bad.
                            err   <= !ovf;
                        end else begin
                            frame_done <= (addr == FRAME_A);
                        end
                    end
                    default: state <= IDLE;
                endcase
                if (cap_next && act_p0) begin
                    wr_en   <= 1'b1;
                    wr_addr <= '0;
                    addr    <= ADDR_W'(1);
                end
            end else if (state == CAPTURE && act_p0) begin
                if (addr != FRAME_A) begin
                    wr_en   <= 1'b1;
                    wr_addr <= addr;
                    addr    <= addr + ADDR_W'(1);
                end else if (!ovf) begin
                    err <= 1'b1;
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_capture.sv
// Scoreboard bench for video_capture driving 640x480 timing (400x525 clocks).
module tb_video_capture;

    localparam int HREZ  = 320;
    localparam int VREZ  = 480;
    localparam int FRAME = HREZ * VREZ;
    localparam int HTOT  = 400;
    localparam int VTOT  = 525;
    localparam int HS_W  = 48;
    localparam int HACT0 = 64;
    localparam int VACT0 = 35;
    localparam int VS_L  = 2;

    logic        clk24 = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] vid_data = '0;
    logic        vid_hsync = 1'b1;
    logic        vid_vsync = 1'b1;
    logic        vid_active_video = 1'b0;
    logic [17:0] wr_addr;
    logic [47:0] wr_data;
    logic        wr_en;
    logic        locked;
    logic        frame_done;
    logic        err;
    logic [11:0] meas_h_active;
    logic [11:0] meas_v_active;
    logic [11:0] meas_h_total;
    logic [11:0] meas_v_total;

    video_capture #(
        .hRez         (HREZ),
        .vRez         (VREZ),
        .hsync_active (1'b0),
        .vsync_active (1'b0)
    ) dut (
        .clk24            (clk24),
        .rst              (rst),
        .vid_data         (vid_data),
        .vid_hsync        (vid_hsync),
        .vid_vsync        (vid_vsync),
        .vid_active_video (vid_active_video),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr_en            (wr_en),
        .locked           (locked),
        .frame_done       (frame_done),
        .err              (err),
        .meas_h_active    (meas_h_active),
        .meas_v_active    (meas_v_active),
        .meas_h_total     (meas_h_total),
        .meas_v_total     (meas_v_total)
    );

    always #5 clk24 = ~clk24;

    typedef struct {
        logic [47:0] data;
        int          addr;
        int          stamp;
    } wr_exp_t;

    wr_exp_t exp_q[$];
    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int err_cnt  = 0;
    int fd_cnt   = 0;
    int max_addr = -1;
    int pushed   = 0;
    int frame_id = 0;
    bit cap      = 1'b0;

    always @(posedge clk24) cyc <= cyc + 1;

    // Output monitor: every write must match the oldest expected write,
    // arriving exactly two clocks after its pixels were presented.
    always @(negedge clk24) begin
        wr_exp_t e;
        if (err) err_cnt++;
        if (frame_done) fd_cnt++;
        if (wr_en) begin
            wr_cnt++;
            if (int'(wr_addr) > max_addr) max_addr = int'(wr_addr);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h cyc=%0d", wr_addr, wr_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (int'(wr_addr) !== e.addr || wr_data !== e.data || cyc != e.stamp + 2) begin
                    errors++;
                    $display("FAIL write addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                             wr_addr, wr_data, cyc, e.addr, e.data, e.stamp + 2);
                end
            end
        end
    end

    task automatic drive_cycle(input int y, input int x, input int act_w);
        int      yy;
        logic    act;
        wr_exp_t e;
        @(negedge clk24);
        yy  = y % VTOT;
        act = (yy >= VACT0) && (yy < VACT0 + VREZ) && (x >= HACT0) && (x < HACT0 + act_w);
        vid_hsync        = (x < HS_W) ? 1'b0 : 1'b1;
        vid_vsync        = (y < VS_L) ? 1'b0 : 1'b1;
        vid_active_video = act;
        vid_data         = {frame_id[15:0], yy[11:0], x[11:0], 8'($urandom)};
        if (act && cap && pushed < FRAME) begin
            e.data  = vid_data;
            e.addr  = pushed;
            e.stamp = cyc;
            exp_q.push_back(e);
            pushed++;
        end
    endtask

    task automatic drive_lines(input int y0, input int y1, input int act_w);
        for (int y = y0; y < y1; y++)
            for (int x = 0; x < HTOT; x++)
                drive_cycle(y, x, act_w);
    endtask

    task automatic new_frame(input int id, input bit cap_on);
        frame_id = id;
        cap      = cap_on;
        pushed   = 0;
        wr_cnt   = 0;
        max_addr = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) @(negedge clk24);
        checks++;
        if (wr_en !== 1'b0 || locked !== 1'b0 || frame_done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl wr_en=%b locked=%b frame_done=%b err=%b required 0000",
                     wr_en, locked, frame_done, err);
        end
        checks++;
        if (wr_addr !== 18'd0 || wr_data !== 48'd0) begin
            errors++;
            $display("FAIL reset_data wr_addr=%0d wr_data=%h required 0", wr_addr, wr_data);
        end
        checks++;
        if ({meas_h_active, meas_v_active, meas_h_total, meas_v_total} !== 48'd0) begin
            errors++;
            $display("FAIL reset_meas %0d/%0d/%0d/%0d required 0/0/0/0",
                     meas_h_active, meas_v_active, meas_h_total, meas_v_total);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk24);
    endtask

    task automatic test_lock;
        new_frame(0, 1'b0);
        err_cnt = 0;
        fd_cnt  = 0;
        drive_lines(0, VTOT, HREZ);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_first_frame locked=%b required 0", locked);
        end
        new_frame(1, 1'b1);
        drive_lines(0, 2, HREZ);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_second_start locked=%b required 1", locked);
        end
        checks++;
        if (meas_h_active !== 12'd320 || meas_v_active !== 12'd480 ||
            meas_h_total !== 12'd400 || meas_v_total !== 12'd525) begin
            errors++;
            $display("FAIL lock_meas %0d/%0d/%0d/%0d required 320/480/400/525",
                     meas_h_active, meas_v_active, meas_h_total, meas_v_total);
        end
    endtask

    task automatic test_capture_frame;
        drive_lines(2, VTOT, HREZ);
        checks++;
        if (wr_cnt != FRAME || exp_q.size() != 0 || max_addr != FRAME - 1) begin
            errors++;
            $display("FAIL capture_count writes=%0d pending=%0d max_addr=%0d required %0d/0/%0d",
                     wr_cnt, exp_q.size(), max_addr, FRAME, FRAME - 1);
        end
        new_frame(2, 1'b1);
        drive_lines(0, 2, HREZ - 1);
        checks++;
        if (fd_cnt != 1 || err_cnt != 0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL frame_done pulses=%0d err=%0d locked=%b required 1/0/1", fd_cnt, err_cnt, locked);
        end
    endtask

    task automatic test_mismatch;
        drive_lines(2, VTOT, HREZ - 1);
        checks++;
        if (wr_cnt != (HREZ - 1) * VREZ || exp_q.size() != 0) begin
            errors++;
            $display("FAIL short_line_writes writes=%0d pending=%0d required %0d/0",
                     wr_cnt, exp_q.size(), (HREZ - 1) * VREZ);
        end
        new_frame(3, 1'b0);
        err_cnt = 0;
        fd_cnt  = 0;
        drive_lines(0, 2, HREZ);
        checks++;
        if (err_cnt != 1 || locked !== 1'b0 || meas_h_active !== 12'd319) begin
            errors++;
            $display("FAIL mismatch_err err=%0d locked=%b h_active=%0d required 1/0/319",
                     err_cnt, locked, meas_h_active);
        end
        drive_lines(2, VTOT, HREZ);
        checks++;
        if (wr_cnt != 0 || locked !== 1'b0 || err_cnt != 1 || fd_cnt != 0) begin
            errors++;
            $display("FAIL unlocked_quiet writes=%0d locked=%b err=%0d fd=%0d required 0/0/1/0",
                     wr_cnt, locked, err_cnt, fd_cnt);
        end
    endtask

    task automatic test_overflow;
        new_frame(4, 1'b1);
        err_cnt = 0;
        fd_cnt  = 0;
        drive_lines(0, 2, HREZ);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL relock_after_mismatch locked=%b required 1", locked);
        end
        drive_lines(2, 2 * VTOT, HREZ);
        checks++;
        if (wr_cnt != FRAME || max_addr != FRAME - 1 || err_cnt != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL overflow writes=%0d max_addr=%0d err=%0d pending=%0d required %0d/%0d/1/0",
                     wr_cnt, max_addr, err_cnt, exp_q.size(), FRAME, FRAME - 1);
        end
        new_frame(5, 1'b0);
        drive_lines(0, 2, HREZ);
        checks++;
        if (err_cnt != 1 || locked !== 1'b0 || fd_cnt != 0 ||
            meas_v_active !== 12'd960 || meas_v_total !== 12'd1050) begin
            errors++;
            $display("FAIL overflow_end err=%0d locked=%b fd=%0d v_active=%0d v_total=%0d required 1/0/0/960/1050",
                     err_cnt, locked, fd_cnt, meas_v_active, meas_v_total);
        end
        drive_lines(2, VTOT, HREZ);
    endtask

    task automatic test_reset_mid;
        new_frame(6, 1'b1);
        err_cnt = 0;
        fd_cnt  = 0;
        drive_lines(0, 2, HREZ);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_before_reset locked=%b required 1", locked);
        end
        drive_lines(2, 200, HREZ);
        for (int x = 0; x < 99; x++) drive_cycle(200, x, HREZ);
        // Pixels from here on are still in the pipeline when reset hits.
        cap = 1'b0;
        drive_cycle(200, 99, HREZ);
        drive_cycle(200, 100, HREZ);
        rst = 1'b1;
        drive_cycle(200, 101, HREZ);
        checks++;
        if (wr_en !== 1'b0 || locked !== 1'b0 || err !== 1'b0 || frame_done !== 1'b0 ||
            wr_addr !== 18'd0 || wr_data !== 48'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs wr_en=%b locked=%b err=%b fd=%b addr=%0d data=%h required all 0",
                     wr_en, locked, err, frame_done, wr_addr, wr_data);
        end
        checks++;
        if ({meas_h_active, meas_v_active, meas_h_total, meas_v_total} !== 48'd0) begin
            errors++;
            $display("FAIL mid_reset_meas %0d/%0d/%0d/%0d required 0/0/0/0",
                     meas_h_active, meas_v_active, meas_h_total, meas_v_total);
        end
        rst = 1'b0;
        for (int x = 102; x < HTOT; x++) drive_cycle(200, x, HREZ);
        drive_lines(201, VTOT, HREZ);
        new_frame(7, 1'b0);
        drive_lines(0, VTOT, HREZ);
        checks++;
        if (locked !== 1'b0 || wr_cnt != 0) begin
            errors++;
            $display("FAIL after_reset_measure locked=%b writes=%0d required 0/0", locked, wr_cnt);
        end
        new_frame(8, 1'b1);
        drive_lines(0, 60, HREZ);
        checks++;
        if (locked !== 1'b1 || err_cnt != 0 || wr_cnt != (60 - VACT0) * HREZ || exp_q.size() != 0) begin
            errors++;
            $display("FAIL relock_after_reset locked=%b err=%0d writes=%0d pending=%0d required 1/0/%0d/0",
                     locked, err_cnt, wr_cnt, exp_q.size(), (60 - VACT0) * HREZ);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_capture_frame();
        test_mismatch();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
